// File: rtl/l2_arbiter.sv
// Shares the unified L2 port between the I-cache and D-cache, one full-line transaction at a time.
// Defining L2_ARB_ROUND_ROBIN_EN alternates ties between the two sides; otherwise the D-side has fixed priority.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic [1:0]            state_dbg
);

  // Handshake: a requester raises read/write with a stable address and holds
  // it until its one-cycle resp pulse; the pulse is combinational from l2_resp.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   i_req;
  logic   d_req;
  logic   grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
  // High when the D-side completed the most recent transaction.
  logic last_d;

  always_comb grant_d = d_req && (!i_req || !last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (l2_resp) begin
      if (state == SERVE_I) last_d <= 1'b0;
      else if (state == SERVE_D) last_d <= 1'b1;
    end
  end
`else
  always_comb grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) state <= grant_d ? SERVE_D : SERVE_I;
        end
        SERVE_I: if (l2_resp) state <= IDLE;
        SERVE_D: if (l2_resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A response landing in the reset cycle must not reach the requester.
  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      SERVE_I: begin
        l2_read    = i_read;
        l2_address = i_address;
        i_resp     = l2_resp && !rst;
      end
      SERVE_D: begin
        l2_read    = d_read;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp && !rst;
      end
      default: ;
    endcase
  end

  assign i_rdata   = l2_rdata;
  assign d_rdata   = l2_rdata;
  assign state_dbg = state;

endmodule
